// File: rtl/branch_hazard_unit_pkg.sv
// Shared WISC pipeline types for the decode-stage hazard logic.
// A tracking entry records whether a stage holds a register writer, whether it is a load, and its rd.
package wisc_pipe_pkg;

    localparam int unsigned REG_W = 3;

    typedef struct packed {
        logic             v;
        logic             ld;
        logic [REG_W-1:0] rd;
    } hz_entry_t;

    localparam hz_entry_t HZ_BUBBLE = '{v: 1'b0, ld: 1'b0, rd: '0};

endpackage

// File: rtl/branch_hazard_unit_if.sv
// Decode-side bundle between the ID stage controller and the branch hazard unit.
// The unit also exports its tracking entries for debug visibility.
interface branch_hazard_unit_if
    import wisc_pipe_pkg::*;
#(
    parameter int unsigned REG_W = wisc_pipe_pkg::REG_W,
    parameter int unsigned CNT_W = 16
);
    logic             id_valid;
    logic             id_is_branch;
    logic [REG_W-1:0] id_rs;
    logic [REG_W-1:0] id_rt;
    logic             id_rs_used;
    logic             id_rt_used;
    logic             id_reg_write;
    logic [REG_W-1:0] id_rd;
    logic             id_is_load;
    logic             pipe_stall_ext;
    logic             flush;
    logic             stall_fd;
    logic [CNT_W-1:0] stall_cnt;
    hz_entry_t        dbg_e_dx;
    hz_entry_t        dbg_e_xm;
    hz_entry_t        dbg_e_mw;

    modport master (
        output id_valid, id_is_branch, id_rs, id_rt, id_rs_used, id_rt_used,
               id_reg_write, id_rd, id_is_load, pipe_stall_ext, flush,
        input  stall_fd, stall_cnt, dbg_e_dx, dbg_e_xm, dbg_e_mw
    );

    modport slave (
        input  id_valid, id_is_branch, id_rs, id_rt, id_rs_used, id_rt_used,
               id_reg_write, id_rd, id_is_load, pipe_stall_ext, flush,
        output stall_fd, stall_cnt, dbg_e_dx, dbg_e_xm, dbg_e_mw
    );

endinterface

// File: rtl/branch_hazard_unit_hazard_match.sv
// Single producer/consumer match: an enabled consumer hits a valid entry writing its specifier.
// Load qualification is folded into the enable by the caller.
module hazard_match
    import wisc_pipe_pkg::*;
(
    input  logic             en,
    input  hz_entry_t        entry,
    input  logic [REG_W-1:0] spec,
    output logic             hit
);

    assign hit = en & entry.v & (entry.rd == spec);

endmodule

// File: rtl/branch_hazard_unit.sv
// Decode-stage stall generator for the WISC branch forwarding path.
// Tracks in-flight destinations in EX/MEM/WB and stalls ID when an operand cannot yet be forwarded.
module branch_hazard_unit
    import wisc_pipe_pkg::*;
#(
    parameter int unsigned REG_W = wisc_pipe_pkg::REG_W,
    parameter int unsigned CNT_W = 16
) (
    input logic           clk,
    input logic           rst_n,
    branch_hazard_unit_if.slave bus
);

    hz_entry_t        e_dx_q, e_xm_q, e_mw_q, e_dx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic h_br_dx, h_br_xm, h_lu_rs, h_lu_rt;
    logic stall;

    // Branches resolve in ID: an ALU result in EX, or load data in MEM, is not yet forwardable.
    hazard_match u_br_dx (
        .en    (bus.id_valid & bus.id_is_branch),
        .entry (e_dx_q),
        .spec  (bus.id_rs),
        .hit   (h_br_dx)
    );

    hazard_match u_br_xm (
        .en    (bus.id_valid & bus.id_is_branch & e_xm_q.ld),
        .entry (e_xm_q),
        .spec  (bus.id_rs),
        .hit   (h_br_xm)
    );

    hazard_match u_lu_rs (
        .en    (bus.id_valid & bus.id_rs_used & e_dx_q.ld),
        .entry (e_dx_q),
        .spec  (bus.id_rs),
        .hit   (h_lu_rs)
    );

    hazard_match u_lu_rt (
        .en    (bus.id_valid & bus.id_rt_used & e_dx_q.ld),
        .entry (e_dx_q),
        .spec  (bus.id_rt),
        .hit   (h_lu_rt)
    );

    // A squashed instruction never stalls.
    assign stall = (h_br_dx | h_br_xm | h_lu_rs | h_lu_rt) & ~bus.flush;

    always_comb begin
        e_dx_d = HZ_BUBBLE;
        if (bus.id_valid & bus.id_reg_write & ~stall & ~bus.flush) begin
            e_dx_d = '{v: 1'b1, ld: bus.id_is_load, rd: bus.id_rd[REG_W-1:0]};
        end
    end

    always_comb begin
        cnt_d = cnt_q;
        if (stall && !(&cnt_q)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_dx_q <= HZ_BUBBLE;
            e_xm_q <= HZ_BUBBLE;
            e_mw_q <= HZ_BUBBLE;
            cnt_q  <= '0;
        end else if (!bus.pipe_stall_ext) begin
            e_dx_q <= e_dx_d;
            e_xm_q <= e_dx_q;
            e_mw_q <= e_xm_q;
            cnt_q  <= cnt_d;
        end
    end

    assign bus.stall_fd  = stall;
    assign bus.stall_cnt = cnt_q;
    assign bus.dbg_e_dx  = e_dx_q;
    assign bus.dbg_e_xm  = e_xm_q;
    assign bus.dbg_e_mw  = e_mw_q;

endmodule

// File: tb/tb_branch_hazard_unit.sv
// Scoreboard bench for branch_hazard_unit: expected stall_fd values are queued per driven cycle.
// A second instance with a 4-bit counter sees the same stimulus to exercise saturation.
module tb_branch_hazard_unit;
    import wisc_pipe_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    branch_hazard_unit_if #(.REG_W(3), .CNT_W(16)) bus ();
    branch_hazard_unit_if #(.REG_W(3), .CNT_W(4))  sbus ();

    assign sbus.id_valid       = bus.id_valid;
    assign sbus.id_is_branch   = bus.id_is_branch;
    assign sbus.id_rs          = bus.id_rs;
    assign sbus.id_rt          = bus.id_rt;
    assign sbus.id_rs_used     = bus.id_rs_used;
    assign sbus.id_rt_used     = bus.id_rt_used;
    assign sbus.id_reg_write   = bus.id_reg_write;
    assign sbus.id_rd          = bus.id_rd;
    assign sbus.id_is_load     = bus.id_is_load;
    assign sbus.pipe_stall_ext = bus.pipe_stall_ext;
    assign sbus.flush          = bus.flush;

    branch_hazard_unit #(.REG_W(3), .CNT_W(16)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    branch_hazard_unit #(.REG_W(3), .CNT_W(4)) u_sat (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (sbus)
    );

    int errors = 0;
    int checks = 0;
    int exp_cnt = 0;
    bit exp_q[$];

    task automatic nop();
        bus.id_valid     = 1'b0;
        bus.id_is_branch = 1'b0;
        bus.id_rs        = 3'd0;
        bus.id_rt        = 3'd0;
        bus.id_rs_used   = 1'b0;
        bus.id_rt_used   = 1'b0;
        bus.id_reg_write = 1'b0;
        bus.id_rd        = 3'd0;
        bus.id_is_load   = 1'b0;
        bus.flush        = 1'b0;
    endtask

    task automatic drive(input logic br, input logic [2:0] rs, input logic [2:0] rt,
                         input logic rsu, input logic rtu, input logic rw,
                         input logic [2:0] rd, input logic ld);
        bus.id_valid     = 1'b1;
        bus.id_is_branch = br;
        bus.id_rs        = rs;
        bus.id_rt        = rt;
        bus.id_rs_used   = rsu;
        bus.id_rt_used   = rtu;
        bus.id_reg_write = rw;
        bus.id_rd        = rd;
        bus.id_is_load   = ld;
    endtask

    // Queue the expected stall_fd for this cycle, compare at the falling edge, then advance.
    task automatic step(input bit s, input string tag);
        bit e;
        exp_q.push_back(s);
        @(negedge clk);
        if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            checks++;
            if (bus.stall_fd !== e) begin
                errors++;
                $display("FAIL %s: stall_fd=%0b expected %0b", tag, bus.stall_fd, e);
            end
            if (e && !bus.pipe_stall_ext) exp_cnt++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        int sat_exp;
        sat_exp = (exp_cnt > 15) ? 15 : exp_cnt;
        checks++;
        if (bus.stall_cnt !== exp_cnt[15:0]) begin
            errors++;
            $display("FAIL %s cnt: stall_cnt=%0d expected %0d", tag, bus.stall_cnt, exp_cnt);
        end
        checks++;
        if (sbus.stall_cnt !== sat_exp[3:0]) begin
            errors++;
            $display("FAIL %s satcnt: stall_cnt=%0d expected %0d", tag, sbus.stall_cnt, sat_exp);
        end
    endtask

    task automatic issue(input string tag, input logic br, input logic [2:0] rs,
                         input logic [2:0] rt, input logic rsu, input logic rtu, input logic rw,
                         input logic [2:0] rd, input logic ld, input int nstall);
        drive(br, rs, rt, rsu, rtu, rw, rd, ld);
        repeat (nstall) step(1'b1, tag);
        step(1'b0, tag);
        nop();
    endtask

    task automatic drain();
        nop();
        repeat (3) step(1'b0, "drain");
    endtask

    task automatic test_reset();
        bus.pipe_stall_ext = 1'b0;
        nop();
        rst_n = 1'b0;
        #12;
        checks++;
        if (bus.stall_fd !== 1'b0 || bus.dbg_e_dx.v !== 1'b0 || bus.dbg_e_xm.v !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: stall_fd=%0b e_dx.v=%0b e_xm.v=%0b expected 0 0 0",
                     bus.stall_fd, bus.dbg_e_dx.v, bus.dbg_e_xm.v);
        end
        check_cnt("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        // LD r3 in EX with a branch on r3 in ID, then reset mid-stall.
        issue("rst_ld", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 0);
        issue("rst_alu", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 0);
        issue("rst_ld2", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 0);
        drive(1'b1, 3'd3, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.stall_fd !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: stall_fd=%0b expected 1", bus.stall_fd);
        end
        #1 rst_n = 1'b0;
        #1;
        checks++;
        if (bus.stall_fd !== 1'b0 || bus.dbg_e_dx.v !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid: stall_fd=%0b e_dx.v=%0b expected 0 0",
                     bus.stall_fd, bus.dbg_e_dx.v);
        end
        exp_cnt = 0;
        check_cnt("rst_mid");
        nop();
        #1 rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_alu_branch();
        drain();
        issue("add_r2", 1'b0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 0);
        issue("beqz_r2", 1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1);
        check_cnt("alu_br_adj");
        drain();
        issue("add_r2b", 1'b0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 0);
        issue("beqz_r5", 1'b1, 3'd5, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 0);
        drain();
        issue("add_r2c", 1'b0, 3'd0, 3'd1, 1'b1, 1'b1, 1'b1, 3'd2, 1'b0, 0);
        issue("nop_mid", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 0);
        issue("beqz_r2_gap", 1'b1, 3'd2, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 0);
        check_cnt("alu_br_other");
    endtask

    task automatic test_ld_branch();
        drain();
        issue("ld_r4", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 0);
        issue("bnez_r4", 1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2);
        check_cnt("ld_br_adj");
        drain();
        issue("ld_r4b", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 0);
        issue("nop_ld", 1'b0, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 0);
        issue("bnez_r4_gap", 1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 1);
        check_cnt("ld_br_gap");
    endtask

    task automatic test_load_use();
        drain();
        issue("ld_r1", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 0);
        issue("add_rt_r1", 1'b0, 3'd7, 3'd1, 1'b1, 1'b1, 1'b1, 3'd6, 1'b0, 1);
        check_cnt("lu_rt");
        drain();
        issue("ld_r1b", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 0);
        issue("add_rt_unused", 1'b0, 3'd7, 3'd1, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 0);
        check_cnt("lu_rt_unused");
    endtask

    task automatic test_freeze();
        drain();
        issue("fz_ld_r4", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 0);
        drive(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        step(1'b1, "fz_first");
        bus.pipe_stall_ext = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, "fz_hold");
            checks++;
            if (bus.dbg_e_xm !== hz_entry_t'({1'b1, 1'b1, 3'd4}) || bus.dbg_e_dx.v !== 1'b0) begin
                errors++;
                $display("FAIL fz_entries: e_xm=%b e_dx.v=%0b expected 114 0",
                         bus.dbg_e_xm, bus.dbg_e_dx.v);
            end
            check_cnt("fz_hold");
        end
        bus.pipe_stall_ext = 1'b0;
        step(1'b1, "fz_release");
        step(1'b0, "fz_go");
        nop();
        check_cnt("fz_total");
    endtask

    task automatic test_flush();
        drain();
        issue("fl_ld_r4", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 0);
        // Flushed LD r5 that reads r4: hazard present but squashed, so no entry may appear.
        drive(1'b0, 3'd4, 3'd0, 1'b1, 1'b0, 1'b1, 3'd5, 1'b1);
        bus.flush = 1'b1;
        step(1'b0, "fl_hazard");
        checks++;
        if (bus.dbg_e_dx.v !== 1'b0) begin
            errors++;
            $display("FAIL fl_bubble: e_dx.v=%0b expected 0", bus.dbg_e_dx.v);
        end
        nop();
        issue("fl_use_r5", 1'b0, 3'd5, 3'd0, 1'b1, 1'b0, 1'b1, 3'd6, 1'b0, 0);
        // Flush during a freeze: the freeze wins and entries hold.
        drain();
        issue("ff_ld_r4", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 0);
        drive(1'b1, 3'd4, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0);
        bus.flush = 1'b1;
        bus.pipe_stall_ext = 1'b1;
        step(1'b0, "ff_frozen");
        checks++;
        if (bus.dbg_e_dx !== hz_entry_t'({1'b1, 1'b1, 3'd4})) begin
            errors++;
            $display("FAIL ff_hold: e_dx=%b expected 114", bus.dbg_e_dx);
        end
        bus.pipe_stall_ext = 1'b0;
        step(1'b0, "ff_release");
        checks++;
        if (bus.dbg_e_dx.v !== 1'b0 || bus.dbg_e_xm !== hz_entry_t'({1'b1, 1'b1, 3'd4})) begin
            errors++;
            $display("FAIL ff_after: e_dx.v=%0b e_xm=%b expected 0 114",
                     bus.dbg_e_dx.v, bus.dbg_e_xm);
        end
        nop();
        check_cnt("flush");
    endtask

    task automatic test_saturation();
        drain();
        rst_n = 1'b0;
        #2 rst_n = 1'b1;
        exp_cnt = 0;
        check_cnt("sat_reset");
        for (int i = 0; i < 10; i++) begin
            issue("sat_ld", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 0);
            issue("sat_br", 1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2);
        end
        check_cnt("sat_20");
        issue("sat_ld2", 1'b0, 3'd0, 3'd0, 1'b1, 1'b0, 1'b1, 3'd1, 1'b1, 0);
        issue("sat_br2", 1'b1, 3'd1, 3'd0, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 2);
        check_cnt("sat_hold");
    endtask

    initial begin
        test_reset();
        test_alu_branch();
        test_ld_branch();
        test_load_use();
        test_freeze();
        test_flush();
        test_saturation();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
